// File: rtl/weight_fetch_seq.sv
// Streams WORDS_PER_LOAD consecutive ROM words from a per-layer/phase base into q; valid two edges after the last address is issued.
// No backpressure: start is taken only when idle, ignored mid-load; flush aborts at the next edge and wins over start.
module weight_fetch_seq #(
  parameter int DATA_LEN       = 16,
  parameter int WORD_ELEMS     = 9,
  parameter int WORDS_PER_LOAD = 4,
  parameter int ADDR_W         = 8,
  parameter int NUM_LAYERS     = 5,
  parameter int LAYER_STRIDE   = 32,
  parameter int PHASE_STRIDE   = 4,
  parameter int LAYER_W        = 4
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         start,
  input  logic                                         flush,
  input  logic [LAYER_W-1:0]                           layer,
  input  logic [2:0]                                   phase,
  output logic                                         rom_en,
  output logic [ADDR_W-1:0]                            rom_addr,
  input  logic [WORD_ELEMS*DATA_LEN-1:0]               rom_data,
  output logic                                         busy,
  output logic                                         valid,
  output logic                                         err,
  output logic [WORDS_PER_LOAD*WORD_ELEMS*DATA_LEN-1:0] q
);

  localparam int WORD_W = WORD_ELEMS * DATA_LEN;
  localparam int CNT_W  = (WORDS_PER_LOAD > 1) ? $clog2(WORDS_PER_LOAD) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS_PER_LOAD - 1);

  typedef enum logic [1:0] {IDLE, FETCH, LAST} state_t;

  state_t            state;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  cap_idx;
  logic              cap_vld;
  logic              layer_ok;
  logic [ADDR_W-1:0] base_addr;

  always_comb begin
    layer_ok  = (32'(layer) < 32'(NUM_LAYERS));
    base_addr = ADDR_W'(32'(layer) * 32'(LAYER_STRIDE) + 32'(phase) * 32'(PHASE_STRIDE));
  end

  // cap_vld/cap_idx trail the issued address by one edge to match the registered ROM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      issue_cnt <= '0;
      cap_idx   <= '0;
      cap_vld   <= 1'b0;
      rom_en    <= 1'b0;
      rom_addr  <= '0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      err       <= 1'b0;
      q         <= '0;
    end else begin
      err     <= 1'b0;
      cap_vld <= 1'b0;
      if (cap_vld && !flush) begin
        for (int k = 0; k < WORDS_PER_LOAD; k++) begin
          if (cap_idx == CNT_W'(k)) q[k*WORD_W +: WORD_W] <= rom_data;
        end
      end
      if (flush) begin
        state  <= IDLE;
        rom_en <= 1'b0;
        busy   <= 1'b0;
        valid  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (layer_ok) begin
                state     <= FETCH;
                rom_en    <= 1'b1;
                rom_addr  <= base_addr;
                issue_cnt <= '0;
                busy      <= 1'b1;
                valid     <= 1'b0;
              end else begin
                err <= 1'b1;
              end
            end
          end
          FETCH: begin
            cap_vld <= 1'b1;
            cap_idx <= issue_cnt;
            if (issue_cnt == LAST_IDX) begin
              rom_en <= 1'b0;
              state  <= LAST;
            end else begin
              issue_cnt <= issue_cnt + 1'b1;
              rom_addr  <= rom_addr + 1'b1;
            end
          end
          LAST: begin
            state <= IDLE;
            busy  <= 1'b0;
            valid <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_weight_fetch_seq.sv
// Four configurations of weight_fetch_seq checked every cycle against a load-level model, plus literal checkpoints.
module tb_weight_fetch_seq;

  localparam int WW = 144;
  localparam int QW = 576;
  localparam int NI = 4;

  function automatic int aw_of(int g);
    return (g == 1 || g == 3) ? 5 : 8;
  endfunction
  function automatic int wpl_of(int g);
    return (g == 2) ? 1 : 4;
  endfunction
  function automatic int ls_of(int g);
    return (g == 3) ? 30 : 32;
  endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NI-1:0] start_v;
  logic [NI-1:0] flush_v;
  logic [3:0] layer_v [NI];
  logic [2:0] phase_v [NI];

  logic          d_en [NI];
  logic          d_busy [NI];
  logic          d_valid [NI];
  logic          d_err [NI];
  logic [7:0]    d_addr [NI];
  logic [QW-1:0] d_q [NI];

  int n_chk = 0;
  int n_err = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int A  = aw_of(g);
    localparam int W  = wpl_of(g);
    localparam int LS = ls_of(g);
    logic [A-1:0]    addr;
    logic [W*WW-1:0] qq;
    logic [WW-1:0]   rdata = '0;
    logic            en, bsy, vld, er;

    weight_fetch_seq #(
      .DATA_LEN(16), .WORD_ELEMS(9), .WORDS_PER_LOAD(W), .ADDR_W(A),
      .NUM_LAYERS(5), .LAYER_STRIDE(LS), .PHASE_STRIDE(4), .LAYER_W(4)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start_v[g]), .flush(flush_v[g]),
      .layer(layer_v[g]), .phase(phase_v[g]), .rom_en(en), .rom_addr(addr),
      .rom_data(rdata), .busy(bsy), .valid(vld), .err(er), .q(qq)
    );

    // registered ROM whose word n is n replicated in every element
    always @(posedge clk) if (en) rdata <= {9{16'(addr)}};

    assign d_en[g]    = en;
    assign d_busy[g]  = bsy;
    assign d_valid[g] = vld;
    assign d_err[g]   = er;
    assign d_addr[g]  = 8'(addr);
    assign d_q[g]     = QW'(qq);
  end

  // model: a load is a count of edges since acceptance
  bit            m_act [NI];
  int            m_t [NI];
  int            m_base [NI];
  logic          e_en [NI];
  logic          e_busy [NI];
  logic          e_valid [NI];
  logic          e_err [NI];
  logic [7:0]    e_addr [NI];
  logic [QW-1:0] e_q [NI];

  always @(posedge clk or negedge rst_n) begin
    int t, w, msk, b;
    logic [QW-1:0] nq;
    for (int i = 0; i < NI; i++) begin
      w   = wpl_of(i);
      msk = (1 << aw_of(i)) - 1;
      if (!rst_n) begin
        m_act[i] <= 1'b0; m_t[i] <= 0; m_base[i] <= 0;
        e_en[i] <= 1'b0; e_busy[i] <= 1'b0; e_valid[i] <= 1'b0; e_err[i] <= 1'b0;
        e_addr[i] <= '0; e_q[i] <= '0;
      end else if (flush_v[i]) begin
        m_act[i] <= 1'b0; e_en[i] <= 1'b0; e_busy[i] <= 1'b0;
        e_valid[i] <= 1'b0; e_err[i] <= 1'b0;
      end else if (m_act[i]) begin
        t  = m_t[i] + 1;
        nq = e_q[i];
        e_err[i] <= 1'b0;
        if (t >= 2 && t - 2 < w) nq[(t-2)*WW +: WW] = {9{16'((m_base[i] + t - 2) & msk)}};
        e_en[i] <= (t < w);
        if (t < w) e_addr[i] <= 8'((m_base[i] + t) & msk);
        if (t == w + 1) begin
          m_act[i] <= 1'b0; e_valid[i] <= 1'b1; e_busy[i] <= 1'b0;
        end
        m_t[i] <= t;
        e_q[i] <= nq;
      end else begin
        e_err[i] <= 1'b0;
        if (start_v[i]) begin
          if (int'(layer_v[i]) < 5) begin
            b = (int'(layer_v[i]) * ls_of(i) + int'(phase_v[i]) * 4) & msk;
            m_base[i] <= b; m_t[i] <= 0; m_act[i] <= 1'b1;
            e_valid[i] <= 1'b0; e_busy[i] <= 1'b1; e_en[i] <= 1'b1; e_addr[i] <= 8'(b);
          end else begin
            e_err[i] <= 1'b1;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [QW-1:0] act, input logic [QW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("model rom_en[%0d]", i), QW'(d_en[i]), QW'(e_en[i]));
        chk($sformatf("model rom_addr[%0d]", i), QW'(d_addr[i]), QW'(e_addr[i]));
        chk($sformatf("model busy[%0d]", i), QW'(d_busy[i]), QW'(e_busy[i]));
        chk($sformatf("model valid[%0d]", i), QW'(d_valid[i]), QW'(e_valid[i]));
        chk($sformatf("model err[%0d]", i), QW'(d_err[i]), QW'(e_err[i]));
        chk($sformatf("model q[%0d]", i), d_q[i], e_q[i]);
      end
    end
  end

  task automatic lit(input int i, input logic en, input logic [7:0] addr, input logic bsy,
                     input logic vld, input logic er, input string tag);
    chk({tag, " rom_en"}, QW'(d_en[i]), QW'(en));
    chk({tag, " rom_addr"}, QW'(d_addr[i]), QW'(addr));
    chk({tag, " busy"}, QW'(d_busy[i]), QW'(bsy));
    chk({tag, " valid"}, QW'(d_valid[i]), QW'(vld));
    chk({tag, " err"}, QW'(d_err[i]), QW'(er));
  endtask

  function automatic logic [QW-1:0] qexp(input int base, input int n, input int msk);
    logic [QW-1:0] r = '0;
    for (int k = 0; k < n; k++) r[k*WW +: WW] = {9{16'((base + k) & msk)}};
    return r;
  endfunction

  task automatic load(input int i, input int l, input int p);
    start_v[i] = 1'b1;
    layer_v[i] = 4'(l);
    phase_v[i] = 3'(p);
    @(negedge clk);
    start_v[i] = 1'b0;
  endtask

  initial begin
    start_v = '0;
    flush_v = '0;
    for (int i = 0; i < NI; i++) begin
      layer_v[i] = '0;
      phase_v[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      lit(i, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, $sformatf("reset[%0d]", i));
      chk($sformatf("reset[%0d] q", i), d_q[i], '0);
    end
    cmp_on = 1'b1;
    rst_n  = 1'b1;

    // layer 2 phase 3 accepted on the first edge after reset release
    load(0, 2, 3);
    lit(0, 1'b1, 8'd76, 1'b1, 1'b0, 1'b0, "L2P3 E0");
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      lit(0, 1'b1, 8'(76 + k), 1'b1, 1'b0, 1'b0, $sformatf("L2P3 E%0d", k));
    end
    @(negedge clk);
    lit(0, 1'b0, 8'd79, 1'b1, 1'b0, 1'b0, "L2P3 E4");
    @(negedge clk);
    lit(0, 1'b0, 8'd79, 1'b0, 1'b1, 1'b0, "L2P3 E5");
    chk("L2P3 q", d_q[0], qexp(76, 4, 255));

    // out-of-range layer
    load(0, 7, 0);
    lit(0, 1'b0, 8'd79, 1'b0, 1'b1, 1'b1, "bad layer");
    chk("bad layer q", d_q[0], qexp(76, 4, 255));
    @(negedge clk);
    lit(0, 1'b0, 8'd79, 1'b0, 1'b1, 1'b0, "bad layer after");

    // restart during a load is ignored
    load(0, 1, 0);
    lit(0, 1'b1, 8'd32, 1'b1, 1'b0, 1'b0, "L1 E0");
    @(negedge clk);
    load(0, 0, 0);
    lit(0, 1'b1, 8'd34, 1'b1, 1'b0, 1'b0, "restart E2");
    repeat (3) @(negedge clk);
    lit(0, 1'b0, 8'd35, 1'b0, 1'b1, 1'b0, "restart E5");
    chk("restart q", d_q[0], qexp(32, 4, 255));
    load(0, 0, 1);
    lit(0, 1'b1, 8'd4, 1'b1, 1'b0, 1'b0, "reload clears valid");
    repeat (5) @(negedge clk);
    chk("reload q", d_q[0], qexp(4, 4, 255));

    // flush sampled at E2
    load(0, 0, 2);
    @(negedge clk);
    flush_v[0] = 1'b1;
    @(negedge clk);
    flush_v[0] = 1'b0;
    lit(0, 1'b0, 8'd9, 1'b0, 1'b0, 1'b0, "flush E2");
    chk("flush q", d_q[0], qexp(4, 4, 255));
    flush_v[0] = 1'b1;
    load(0, 2, 0);
    flush_v[0] = 1'b0;
    lit(0, 1'b0, 8'd9, 1'b0, 1'b0, 1'b0, "start+flush");
    repeat (2) @(negedge clk);
    lit(0, 1'b0, 8'd9, 1'b0, 1'b0, 1'b0, "start+flush later");

    // ADDR_W=5
    load(1, 0, 7);
    lit(1, 1'b1, 8'd28, 1'b1, 1'b0, 1'b0, "a5 E0");
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      lit(1, 1'b1, 8'(28 + k), 1'b1, 1'b0, 1'b0, $sformatf("a5 E%0d", k));
    end
    repeat (2) @(negedge clk);
    chk("a5 q", d_q[1], qexp(28, 4, 31));
    load(1, 3, 7);
    lit(1, 1'b1, 8'd28, 1'b1, 1'b0, 1'b0, "a5 L3P7 E0");
    repeat (5) @(negedge clk);

    // ADDR_W=5 wrap from base 30
    load(3, 1, 0);
    lit(3, 1'b1, 8'd30, 1'b1, 1'b0, 1'b0, "wrap E0");
    @(negedge clk);
    lit(3, 1'b1, 8'd31, 1'b1, 1'b0, 1'b0, "wrap E1");
    @(negedge clk);
    lit(3, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0, "wrap E2");
    @(negedge clk);
    lit(3, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0, "wrap E3");
    repeat (2) @(negedge clk);
    chk("wrap q", d_q[3], qexp(30, 4, 31));

    // single-word load
    load(2, 2, 3);
    lit(2, 1'b1, 8'd76, 1'b1, 1'b0, 1'b0, "w1 E0");
    @(negedge clk);
    lit(2, 1'b0, 8'd76, 1'b1, 1'b0, 1'b0, "w1 E1");
    @(negedge clk);
    lit(2, 1'b0, 8'd76, 1'b0, 1'b1, 1'b0, "w1 E2");
    chk("w1 q", d_q[2], qexp(76, 1, 255));

    // asynchronous reset in the middle of a fetch
    load(0, 2, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    lit(0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "async reset");
    chk("async reset q", d_q[0], '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    lit(0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "after reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
